// File: rtl/pid_motion_pkg.sv
// Shared types and helpers for the PID line-follower controller: FSM states,
// A2D channel map, saturation helpers and the gain fixed-point shift.
package pid_motion_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SETTLE,
      CONV_A,
      SHORT,
      CONV_B,
      ERR,
      INTG,
      MUL_P,
      MUL_I,
      MUL_D,
      SUM_R,
      SUM_L
   } state_t;

   localparam int GAIN_W     = 16;
   localparam int GAIN_SHIFT = 12;

   // Board wiring: A-side and B-side A2D channels for each sensor pair.
   function automatic logic [2:0] chnl_map(input logic [7:0] pair, input logic side_b);
      logic [2:0] ch;
      case (pair)
         8'd0:    ch = side_b ? 3'd0 : 3'd1;
         8'd1:    ch = side_b ? 3'd2 : 3'd4;
         8'd2:    ch = side_b ? 3'd7 : 3'd3;
         default: ch = side_b ? 3'd6 : 3'd5;
      endcase
      return ch;
   endfunction

   function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
      return 16'(sat_to(v, 16));
   endfunction

endpackage

// File: rtl/pid_motion_cntrl_sat_mac.sv
// Shared signed multiply by a gain, arithmetic shift back to integer scale,
// and clamp to the 16-bit component range. Purely combinational.
module sat_mac
   import pid_motion_pkg::*;
#(
   parameter int A_W = 13
) (
   input  logic signed [A_W-1:0]    a,
   input  logic signed [GAIN_W-1:0] gain,
   output logic signed [GAIN_W-1:0] result
);

   localparam int P_W = A_W + GAIN_W;

   logic signed [P_W-1:0] prod;
   logic signed [P_W-1:0] scaled;

   assign prod   = P_W'(a) * P_W'(gain);
   assign scaled = prod >>> GAIN_SHIFT;
   assign result = sat16(32'(scaled));

endmodule

// File: rtl/pid_motion_cntrl.sv
// PID line-follower: sequences IR sensor pairs through the shared A2D, forms a
// weighted error and drives saturated signed left/right motor commands.
module pid_motion_cntrl
   import pid_motion_pkg::*;
#(
   parameter int                 NUM_PAIRS  = 3,
   parameter int                 RES_W      = 12,
   parameter int                 OUT_W      = 11,
   parameter int                 SETTLE_CYC = 4096,
   parameter int                 SHORT_CYC  = 64,
   parameter int                 INT_DEC    = 4,
   parameter logic signed [15:0] P_GAIN     = 16'sh3680,
   parameter logic signed [15:0] I_GAIN     = 16'sh0500,
   parameter logic signed [15:0] D_GAIN     = 16'sh0000,
   parameter int                 FWD_MAX    = 'h700,
   parameter logic [7:0]         PWM_ON     = 8'h8C
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic                 cnv_cmplt,
   input  logic [RES_W-1:0]     A2D_res,
   output logic                 start_conv,
   output logic [2:0]           chnnl,
   output logic [NUM_PAIRS-1:0] IR_en,
   output logic [7:0]           LEDs,
   output logic [OUT_W-1:0]     lft,
   output logic [OUT_W-1:0]     rht,
   output logic                 loop_done
);

   localparam int ACC_W  = RES_W + NUM_PAIRS + 1;
   localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int DEC_W  = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
   localparam int TMR_W  = $clog2((SETTLE_CYC > SHORT_CYC) ? SETTLE_CYC : SHORT_CYC) + 1;
   localparam int MAC_W  = RES_W + 1;

   state_t state, nxt_state;

   logic [TMR_W-1:0]        timer;
   logic [PAIR_W-1:0]       pair;
   logic signed [ACC_W-1:0] accum;
   logic signed [ACC_W-1:0] sample;
   logic signed [RES_W-1:0] error, prev_error, intgrl;
   logic signed [RES_W-1:0] lft_reg, rht_reg;
   logic [RES_W-1:0]        fwd;
   logic signed [RES_W:0]   fwd_s;
   logic [DEC_W-1:0]        dec_cnt;
   logic signed [15:0]      pcomp, icomp, dcomp;
   logic signed [MAC_W-1:0] mac_a;
   logic signed [15:0]      mac_g, mac_out;
   logic signed [31:0]      sum_r, sum_l;
   logic [7:0]              pwm_cnt;
   logic                    pwm;
   logic                    start_pulse, settle_done, short_done, last_pair;

   assign settle_done = (timer == TMR_W'(SETTLE_CYC - 1));
   assign short_done  = (timer == TMR_W'(SHORT_CYC - 1));
   assign last_pair   = (pair == PAIR_W'(NUM_PAIRS - 1));
   assign sample      = $signed(ACC_W'(A2D_res) << pair);
   assign fwd_s       = $signed({1'b0, fwd});
   assign sum_r       = 32'(fwd_s) - 32'(pcomp) - 32'(icomp) - 32'(dcomp);
   assign sum_l       = 32'(fwd_s) + 32'(pcomp) + 32'(icomp) + 32'(dcomp);

   assign LEDs  = error[RES_W-1 -: 8];
   assign lft   = lft_reg[RES_W-1 -: OUT_W];
   assign rht   = rht_reg[RES_W-1 -: OUT_W];
   assign IR_en = (pwm && state != IDLE) ? (NUM_PAIRS'(1) << pair) : '0;

   // Dropping go aborts from any state, so no conversion is started on the way out.
   always_comb begin
      nxt_state   = state;
      start_pulse = 1'b0;
      if (!go) begin
         nxt_state = IDLE;
      end else begin
         case (state)
            IDLE:   nxt_state = SETTLE;
            SETTLE: if (settle_done) begin
                       nxt_state   = CONV_A;
                       start_pulse = 1'b1;
                    end
            CONV_A: if (cnv_cmplt) nxt_state = SHORT;
            SHORT:  if (short_done) begin
                       nxt_state   = CONV_B;
                       start_pulse = 1'b1;
                    end
            CONV_B: if (cnv_cmplt) nxt_state = last_pair ? ERR : SETTLE;
            ERR:    nxt_state = INTG;
            INTG:   nxt_state = MUL_P;
            MUL_P:  nxt_state = MUL_I;
            MUL_I:  nxt_state = MUL_D;
            MUL_D:  nxt_state = SUM_R;
            SUM_R:  nxt_state = SUM_L;
            SUM_L:  nxt_state = SETTLE;
            default: nxt_state = IDLE;
         endcase
      end
   end

   always_comb begin
      mac_a = '0;
      mac_g = '0;
      case (state)
         MUL_P: begin
            mac_a = MAC_W'(error);
            mac_g = P_GAIN;
         end
         MUL_I: begin
            mac_a = MAC_W'(intgrl);
            mac_g = I_GAIN;
         end
         MUL_D: begin
            mac_a = MAC_W'(error) - MAC_W'(prev_error);
            mac_g = D_GAIN;
         end
         default: ;
      endcase
   end

   sat_mac #(.A_W(MAC_W)) u_mac (
      .a      (mac_a),
      .gain   (mac_g),
      .result (mac_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         pair       <= '0;
         accum      <= '0;
         error      <= '0;
         prev_error <= '0;
         intgrl     <= '0;
         fwd        <= '0;
         dec_cnt    <= '0;
         pcomp      <= '0;
         icomp      <= '0;
         dcomp      <= '0;
         lft_reg    <= '0;
         rht_reg    <= '0;
         start_conv <= 1'b0;
         chnnl      <= '0;
         loop_done  <= 1'b0;
      end else begin
         state      <= nxt_state;
         timer      <= (nxt_state == state && (state == SETTLE || state == SHORT)) ?
                       timer + TMR_W'(1) : '0;
         start_conv <= start_pulse;
         loop_done  <= 1'b0;
         if (start_pulse) chnnl <= chnl_map(8'(pair), state == SHORT);
         if (!go) begin
            fwd     <= '0;
            lft_reg <= '0;
            rht_reg <= '0;
            accum   <= '0;
            pair    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  accum <= '0;
                  pair  <= '0;
               end
               CONV_A: if (cnv_cmplt) accum <= accum + sample;
               CONV_B: if (cnv_cmplt) begin
                  accum <= accum - sample;
                  if (!last_pair) pair <= pair + PAIR_W'(1);
               end
               ERR: begin
                  prev_error <= error;
                  error      <= RES_W'(sat_to(32'(accum), RES_W));
               end
               // Integrator is decimated so I_GAIN stays usable at the full loop rate.
               INTG: begin
                  if (dec_cnt == DEC_W'(INT_DEC - 1)) begin
                     dec_cnt <= '0;
                     intgrl  <= RES_W'(sat_to(32'(intgrl) + 32'(error >>> 4), RES_W));
                  end else begin
                     dec_cnt <= dec_cnt + DEC_W'(1);
                  end
               end
               MUL_P: pcomp <= mac_out;
               MUL_I: icomp <= mac_out;
               MUL_D: dcomp <= mac_out;
               SUM_R: rht_reg <= RES_W'(sat_to(sum_r, RES_W));
               SUM_L: begin
                  lft_reg   <= RES_W'(sat_to(sum_l, RES_W));
                  loop_done <= 1'b1;
                  if (fwd < RES_W'(FWD_MAX)) fwd <= fwd + RES_W'(1);
                  pair  <= '0;
                  accum <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   // Emitter PWM runs freely; a new period only starts while go is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         pwm     <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF && go) pwm <= 1'b1;
         else if (pwm_cnt == PWM_ON) pwm <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pid_motion_cntrl.sv
// Bench for pid_motion_cntrl: an A2D responder feeds per-pair sensor values and
// a reference loop model queues expected motor commands for each loop_done.
module tb_pid_motion_cntrl;

   localparam int SETTLE  = 16;
   localparam int SHORT_C = 8;
   localparam int INT_DEC = 4;
   localparam int PG      = 'h3680;
   localparam int IG      = 'h0500;
   localparam int DG      = 'h1000;
   localparam int FWD_MAX = 'h700;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        cnv_cmplt;
   logic [11:0] A2D_res;
   logic        start_conv;
   logic [2:0]  chnnl;
   logic [2:0]  IR_en;
   logic [7:0]  LEDs;
   logic [10:0] lft, rht;
   logic        loop_done;

   logic        resp_cmplt = 1'b0;
   logic        late_cmplt = 1'b0;
   logic [11:0] resp_res = 12'h0;

   typedef struct {
      logic [10:0] lft;
      logic [10:0] rht;
      logic [7:0]  leds;
   } exp_t;

   exp_t exp_q[$];
   int   a_val[3];
   int   b_val[3];
   int   checks = 0;
   int   passes = 0;
   int   sc_count = 0;
   int   m_fwd, m_err, m_prev, m_int, m_dec;

   assign cnv_cmplt = resp_cmplt | late_cmplt;
   assign A2D_res   = late_cmplt ? 12'hFFF : resp_res;

   pid_motion_cntrl #(
      .NUM_PAIRS (3),
      .RES_W     (12),
      .OUT_W     (11),
      .SETTLE_CYC(SETTLE),
      .SHORT_CYC (SHORT_C),
      .INT_DEC   (INT_DEC),
      .P_GAIN    (16'sh3680),
      .I_GAIN    (16'sh0500),
      .D_GAIN    (16'sh1000),
      .FWD_MAX   ('h700),
      .PWM_ON    (8'h8C)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .cnv_cmplt (cnv_cmplt),
      .A2D_res   (A2D_res),
      .start_conv(start_conv),
      .chnnl     (chnnl),
      .IR_en     (IR_en),
      .LEDs      (LEDs),
      .lft       (lft),
      .rht       (rht),
      .loop_done (loop_done)
   );

   always #5 clk = ~clk;

   function automatic int chan_value(input logic [2:0] ch);
      case (ch)
         3'd1:    return a_val[0];
         3'd0:    return b_val[0];
         3'd4:    return a_val[1];
         3'd2:    return b_val[1];
         3'd3:    return a_val[2];
         3'd7:    return b_val[2];
         default: return 0;
      endcase
   endfunction

   function automatic int sat(input int v, input int w);
      int hi, lo;
      hi = (1 <<< (w - 1)) - 1;
      lo = -(1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // A2D model: answers each start_conv two cycles later with the channel's value.
   always begin
      logic [2:0] ch;
      @(negedge clk);
      if (start_conv === 1'b1 && rst_n === 1'b1) begin
         ch = chnnl;
         repeat (2) @(negedge clk);
         resp_res   = 12'(chan_value(ch));
         resp_cmplt = 1'b1;
         @(negedge clk);
         resp_cmplt = 1'b0;
         resp_res   = 12'h0;
      end
   end

   always @(negedge clk) if (start_conv === 1'b1) sc_count++;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic setTable(input int a0, b0, a1, b1, a2, b2);
      a_val[0] = a0; b_val[0] = b0;
      a_val[1] = a1; b_val[1] = b1;
      a_val[2] = a2; b_val[2] = b2;
   endtask

   task automatic modelReset();
      m_fwd = 0; m_err = 0; m_prev = 0; m_int = 0; m_dec = 0;
   endtask

   task automatic applyStimulus(input int a0, b0, a1, b1, a2, b2);
      int acc, p, i, d, l, r;
      exp_t e;
      setTable(a0, b0, a1, b1, a2, b2);
      acc    = (a0 - b0) + 2 * (a1 - b1) + 4 * (a2 - b2);
      m_prev = m_err;
      m_err  = sat(acc, 12);
      if (m_dec == INT_DEC - 1) begin
         m_dec = 0;
         m_int = sat(m_int + (m_err >>> 4), 12);
      end else begin
         m_dec++;
      end
      p = sat((m_err * PG) >>> 12, 16);
      i = sat((m_int * IG) >>> 12, 16);
      d = sat(((m_err - m_prev) * DG) >>> 12, 16);
      r = sat(m_fwd - p - i - d, 12);
      l = sat(m_fwd + p + i + d, 12);
      if (m_fwd < FWD_MAX) m_fwd++;
      e.lft  = l[11:1];
      e.rht  = r[11:1];
      e.leds = m_err[11:4];
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      bit   seen;
      exp_t e;
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (loop_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      e = exp_q.pop_front();
      if (!seen) begin
         checkVal({tag, "_loop_done_timeout"}, 32'd0, 32'd1);
      end else begin
         checkVal({tag, "_lft"}, 32'(lft), 32'(e.lft));
         checkVal({tag, "_rht"}, 32'(rht), 32'(e.rht));
         checkVal({tag, "_leds"}, 32'(LEDs), 32'(e.leds));
      end
   endtask

   task automatic doReset();
      go    = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   initial begin
      int base;
      bit hit;

      // Reset state and idle behaviour with go low
      go = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkVal("rst_lft", 32'(lft), 32'd0);
      checkVal("rst_rht", 32'(rht), 32'd0);
      checkVal("rst_start_conv", 32'(start_conv), 32'd0);
      checkVal("rst_loop_done", 32'(loop_done), 32'd0);
      checkVal("rst_chnnl", 32'(chnnl), 32'd0);
      checkVal("rst_ir_en", 32'(IR_en), 32'd0);
      checkVal("rst_leds", 32'(LEDs), 32'd0);
      rst_n = 1'b1;
      modelReset();
      base = sc_count;
      repeat (2000) @(negedge clk);
      checkVal("idle_no_start_conv", 32'(sc_count - base), 32'd0);

      // Balanced sensors: zero error, outputs follow the forward ramp
      applyStimulus('h800, 'h800, 'h800, 'h800, 'h800, 'h800);
      go = 1'b1;
      checkOutput("bal1");
      applyStimulus('h800, 'h800, 'h800, 'h800, 'h800, 'h800);
      checkOutput("bal2");
      applyStimulus('h800, 'h800, 'h800, 'h800, 'h800, 'h800);
      checkOutput("bal3");

      // Saturating error, positive then negative
      applyStimulus('hFFF, 'h000, 'h800, 'h800, 'h800, 'h800);
      checkOutput("satpos");
      checkVal("satpos_lft_const", 32'(lft), 32'h3FF);
      checkVal("satpos_rht_const", 32'(rht), 32'h400);
      checkVal("satpos_leds_const", 32'(LEDs), 32'h7F);
      applyStimulus('h000, 'hFFF, 'h800, 'h800, 'h800, 'h800);
      checkOutput("satneg");
      checkVal("satneg_leds_const", 32'(LEDs), 32'h80);

      // Constant error 0x100 over 8 loops exercises the decimated integrator
      doReset();
      applyStimulus('h900, 'h800, 'h800, 'h800, 'h800, 'h800);
      go = 1'b1;
      checkOutput("intg1");
      for (int k = 2; k <= 8; k++) begin
         applyStimulus('h900, 'h800, 'h800, 'h800, 'h800, 'h800);
         checkOutput($sformatf("intg%0d", k));
      end

      // Error step 0 -> 0x40 through pair 1 exercises the derivative term
      doReset();
      applyStimulus('h800, 'h800, 'h800, 'h800, 'h800, 'h800);
      go = 1'b1;
      checkOutput("dstep0");
      applyStimulus('h800, 'h800, 'h820, 'h800, 'h800, 'h800);
      checkOutput("dstep1");
      applyStimulus('h800, 'h800, 'h820, 'h800, 'h800, 'h800);
      checkOutput("dstep2");

      // Drop go during the second SHORT wait of the next loop
      setTable('h800, 'h800, 'h800, 'h800, 'h800, 'h800);
      base = sc_count;
      hit = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (sc_count >= base + 3) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) checkVal("abort_third_start_timeout", 32'd0, 32'd1);
      repeat (5) @(negedge clk);
      go = 1'b0;
      m_fwd = 0;
      @(negedge clk);
      checkVal("abort_lft", 32'(lft), 32'd0);
      checkVal("abort_rht", 32'(rht), 32'd0);
      checkVal("abort_ir_en", 32'(IR_en), 32'd0);
      checkVal("abort_leds_hold", 32'(LEDs), 32'h04);
      base = sc_count;
      late_cmplt = 1'b1;
      @(negedge clk);
      late_cmplt = 1'b0;
      repeat (40) @(negedge clk);
      checkVal("abort_no_start_conv", 32'(sc_count - base), 32'd0);
      checkVal("abort_late_lft", 32'(lft), 32'd0);

      // Resume: accumulator and ramp restart, integrator and error carried over
      applyStimulus('h800, 'h800, 'h800, 'h800, 'h810, 'h800);
      go = 1'b1;
      checkOutput("resume");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
